// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard/debug control block.
package mips_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned REG_ZERO    = 0;

endpackage

// File: rtl/mips_fwd_select.sv
// Priority forwarding match of one EX operand across the downstream stages.
module mips_fwd_select
  import mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]            i_operand,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_stage_rd,
  input  logic [FWD_STAGES-1:0]            i_stage_regwrite,
  output logic [FWD_SEL_W-1:0]             o_sel
);

  // Scan oldest to youngest so the youngest matching stage is the last writer.
  always_comb begin
    o_sel = FWD_SEL_W'(FWD_REGFILE);
    if (i_operand != REG_ADDR_W'(REG_ZERO)) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (i_stage_regwrite[k-1] &&
            (i_stage_rd[k*REG_ADDR_W-1 -: REG_ADDR_W] == i_operand)) begin
          o_sel = FWD_SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Forwarding, load-use stall, flush and run/step/halt gating for the 5-stage core,
// plus saturating cycle and stall counters for the debug unit.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned FWD_SEL_W  = $clog2(FWD_STAGES + 1),
  parameter int unsigned CNT_W      = 32
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_run,
  input  logic                            i_step,
  input  logic [REG_ADDR_W-1:0]           i_rs_id,
  input  logic [REG_ADDR_W-1:0]           i_rt_id,
  input  logic [REG_ADDR_W-1:0]           i_rs_ex,
  input  logic [REG_ADDR_W-1:0]           i_rt_ex,
  input  logic [REG_ADDR_W-1:0]           i_rd_ex,
  input  logic                            i_memread_ex,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_stage_rd,
  input  logic [FWD_STAGES-1:0]           i_stage_regwrite,
  input  logic                            i_branch_taken,
  input  logic                            i_halt_wb,
  output logic [FWD_SEL_W-1:0]            o_fwd_a,
  output logic [FWD_SEL_W-1:0]            o_fwd_b,
  output logic                            o_pipe_en,
  output logic                            o_pc_en,
  output logic                            o_if_id_en,
  output logic                            o_if_id_flush,
  output logic                            o_id_ex_bubble,
  output logic [1:0]                      o_state,
  output logic                            o_halted,
  output logic [CNT_W-1:0]                o_cycle_cnt,
  output logic [CNT_W-1:0]                o_stall_cnt
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             pipe_en_c;
  logic             stall_c;

  mips_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FWD_SEL_W  (FWD_SEL_W)
  ) u_fwd_a (
    .i_operand        (i_rs_ex),
    .i_stage_rd       (i_stage_rd),
    .i_stage_regwrite (i_stage_regwrite),
    .o_sel            (o_fwd_a)
  );

  mips_fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FWD_SEL_W  (FWD_SEL_W)
  ) u_fwd_b (
    .i_operand        (i_rt_ex),
    .i_stage_rd       (i_stage_rd),
    .i_stage_regwrite (i_stage_regwrite),
    .o_sel            (o_fwd_b)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      halted_q    <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: a halt reaching WB while the pipe advances overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run)       state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN:  if (!i_run) state_d = ST_IDLE;
      ST_STEP: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (pipe_en_c && i_halt_wb) state_d = ST_HALT;
    halted_d = (state_d == ST_HALT);
  end

  // State-decoded global enable.
  always_comb begin
    pipe_en_c = 1'b0;
    if ((state_q == ST_RUN) || (state_q == ST_STEP)) pipe_en_c = 1'b1;
  end

  // Load-use hazard; a stall suppresses the branch flush so decode can retry it.
  always_comb begin
    stall_c = i_memread_ex && (i_rd_ex != REG_ADDR_W'(REG_ZERO)) &&
              ((i_rd_ex == i_rs_id) || (i_rd_ex == i_rt_id));
    o_pipe_en      = pipe_en_c;
    o_pc_en        = pipe_en_c && !stall_c;
    o_if_id_en     = pipe_en_c && !stall_c;
    o_id_ex_bubble = pipe_en_c && stall_c;
    o_if_id_flush  = pipe_en_c && i_branch_taken && !stall_c;
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pipe_en_c && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pipe_en_c && stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign o_state     = state_q;
  assign o_halted    = halted_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: directed scenarios plus randomized
// cycles checked against a behavioural model of the control rules.
module tb_mips_hazard_ctrl;

  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, step = 1'b0;
  logic [4:0]  rs_id = '0, rt_id = '0, rs_ex = '0, rt_ex = '0, rd_ex = '0;
  logic        memread = 1'b0;
  logic [9:0]  stage_rd = '0;
  logic [1:0]  stage_rw = '0;
  logic        br = 1'b0, halt = 1'b0;

  logic [1:0]  fwd_a, fwd_b, state;
  logic        pipe_en, pc_en, if_id_en, flush, bubble, halted;
  logic [31:0] cyc_cnt, stl_cnt;

  logic [1:0]  fwd_a4, fwd_b4, state4;
  logic        pipe_en4, pc_en4, if_id_en4, flush4, bubble4, halted4;
  logic [3:0]  cyc_cnt4, stl_cnt4;

  int     n_checks = 0;
  int     n_errors = 0;
  int     m_state;
  longint m_cyc, m_stl, m_cyc4, m_stl4;

  always #5 clk = ~clk;

  mips_hazard_ctrl dut (
    .i_clock(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
    .i_rs_id(rs_id), .i_rt_id(rt_id), .i_rs_ex(rs_ex), .i_rt_ex(rt_ex),
    .i_rd_ex(rd_ex), .i_memread_ex(memread), .i_stage_rd(stage_rd),
    .i_stage_regwrite(stage_rw), .i_branch_taken(br), .i_halt_wb(halt),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_pipe_en(pipe_en), .o_pc_en(pc_en),
    .o_if_id_en(if_id_en), .o_if_id_flush(flush), .o_id_ex_bubble(bubble),
    .o_state(state), .o_halted(halted), .o_cycle_cnt(cyc_cnt), .o_stall_cnt(stl_cnt)
  );

  mips_hazard_ctrl #(.CNT_W(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
    .i_rs_id(rs_id), .i_rt_id(rt_id), .i_rs_ex(rs_ex), .i_rt_ex(rt_ex),
    .i_rd_ex(rd_ex), .i_memread_ex(memread), .i_stage_rd(stage_rd),
    .i_stage_regwrite(stage_rw), .i_branch_taken(br), .i_halt_wb(halt),
    .o_fwd_a(fwd_a4), .o_fwd_b(fwd_b4), .o_pipe_en(pipe_en4), .o_pc_en(pc_en4),
    .o_if_id_en(if_id_en4), .o_if_id_flush(flush4), .o_id_ex_bubble(bubble4),
    .o_state(state4), .o_halted(halted4), .o_cycle_cnt(cyc_cnt4), .o_stall_cnt(stl_cnt4)
  );

  function automatic int ref_fwd(logic [4:0] op);
    if (op == 5'd0) return 0;
    for (int k = 1; k <= 2; k++)
      if (stage_rw[k-1] && (stage_rd[k*5-1 -: 5] == op)) return k;
    return 0;
  endfunction

  function automatic bit ref_stall();
    return memread && (rd_ex != 5'd0) && ((rd_ex == rs_id) || (rd_ex == rt_id));
  endfunction

  function automatic bit ref_pe();
    return (m_state == 1) || (m_state == 2);
  endfunction

  // Advance one clock and update the model from the inputs seen during the cycle.
  task automatic tick();
    bit pe, st;
    int ns;
    pe = ref_pe();
    st = ref_stall();
    if (pe) begin
      if (m_cyc < MAX32) m_cyc++;
      if (m_cyc4 < MAX4) m_cyc4++;
      if (st && m_stl < MAX32) m_stl++;
      if (st && m_stl4 < MAX4) m_stl4++;
    end
    case (m_state)
      0:       ns = run ? 1 : (step ? 2 : 0);
      1:       ns = run ? 1 : 0;
      2:       ns = 0;
      default: ns = 3;
    endcase
    if (pe && halt) ns = 3;
    @(posedge clk);
    #1;
    m_state = ns;
  endtask

  task automatic clear_inputs();
    run = 0; step = 0; halt = 0; br = 0; memread = 0;
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0;
    stage_rd = 0; stage_rw = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
    m_state = 0; m_cyc = 0; m_stl = 0; m_cyc4 = 0; m_stl4 = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    run = 1;
    tick(); tick(); tick();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (state !== 2'd0 || halted !== 1'b0 || cyc_cnt !== 32'd0 || stl_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_regs state=%0d halted=%0b cyc=%0d stl=%0d expected 0 0 0 0",
               state, halted, cyc_cnt, stl_cnt);
    end
    n_checks++;
    if (pipe_en !== 1'b0 || pc_en !== 1'b0 || if_id_en !== 1'b0 || flush !== 1'b0 || bubble !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_comb pe=%0b pc=%0b ifid=%0b fl=%0b bub=%0b expected all 0",
               pipe_en, pc_en, if_id_en, flush, bubble);
    end
    rst_n = 1;
    do_reset();
  endtask

  task automatic test_forwarding();
    do_reset();
    run = 1;
    tick();
    stage_rd = {5'd3, 5'd3}; stage_rw = 2'b11; rs_ex = 5'd3; rt_ex = 5'd7;
    #1;
    n_checks++;
    if (fwd_a !== 2'd1) begin
      n_errors++;
      $display("FAIL fwd_youngest got=%0d expected=1", fwd_a);
    end
    n_checks++;
    if (fwd_b !== 2'd0) begin
      n_errors++;
      $display("FAIL fwd_b_nomatch got=%0d expected=0", fwd_b);
    end
    stage_rw = 2'b10;
    #1;
    n_checks++;
    if (fwd_a !== 2'd2) begin
      n_errors++;
      $display("FAIL fwd_older got=%0d expected=2", fwd_a);
    end
    stage_rd = {5'd9, 5'd0}; stage_rw = 2'b01; rs_ex = 5'd0; rt_ex = 5'd9;
    #1;
    n_checks++;
    if (fwd_a !== 2'd0) begin
      n_errors++;
      $display("FAIL fwd_r0 got=%0d expected=0", fwd_a);
    end
    n_checks++;
    if (fwd_b !== 2'd0) begin
      n_errors++;
      $display("FAIL fwd_b_no_regwrite got=%0d expected=0", fwd_b);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    run = 1;
    tick();
    memread = 1; rd_ex = 5'd5; rt_id = 5'd5; rs_id = 5'd1;
    #1;
    n_checks++;
    if (pc_en !== 1'b0 || if_id_en !== 1'b0 || bubble !== 1'b1 || stl_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL load_use pc=%0b ifid=%0b bub=%0b stl=%0d expected 0 0 1 0",
               pc_en, if_id_en, bubble, stl_cnt);
    end
    br = 1;
    #1;
    n_checks++;
    if (flush !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_over_branch flush=%0b expected=0", flush);
    end
    tick();
    n_checks++;
    if (stl_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL stall_cnt got=%0d expected=1", stl_cnt);
    end
    memread = 0;
    #1;
    n_checks++;
    if (flush !== 1'b1 || pc_en !== 1'b1 || bubble !== 1'b0) begin
      n_errors++;
      $display("FAIL branch_flush fl=%0b pc=%0b bub=%0b expected 1 1 0", flush, pc_en, bubble);
    end
    rd_ex = 5'd0; memread = 1; rt_id = 5'd0;
    #1;
    n_checks++;
    if (bubble !== 1'b0) begin
      n_errors++;
      $display("FAIL load_r0 bub=%0b expected=0", bubble);
    end
  endtask

  task automatic test_step();
    do_reset();
    for (int p = 1; p <= 2; p++) begin
      step = 1;
      tick();
      step = 0;
      #1;
      n_checks++;
      if (pipe_en !== 1'b1 || state !== 2'd2) begin
        n_errors++;
        $display("FAIL step_active pulse=%0d pe=%0b state=%0d expected 1 2", p, pipe_en, state);
      end
      tick();
      n_checks++;
      if (pipe_en !== 1'b0 || state !== 2'd0 || cyc_cnt !== 32'(p)) begin
        n_errors++;
        $display("FAIL step_done pulse=%0d pe=%0b state=%0d cyc=%0d expected 0 0 %0d",
                 p, pipe_en, state, cyc_cnt, p);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1;
    tick(); tick();
    halt = 1;
    tick();
    halt = 0;
    n_checks++;
    if (state !== 2'd3 || halted !== 1'b1 || pipe_en !== 1'b0 || cyc_cnt !== 32'd2) begin
      n_errors++;
      $display("FAIL halt_enter state=%0d halted=%0b pe=%0b cyc=%0d expected 3 1 0 2",
               state, halted, pipe_en, cyc_cnt);
    end
    step = 1;
    repeat (4) tick();
    step = 0;
    n_checks++;
    if (state !== 2'd3 || cyc_cnt !== 32'd2 || pipe_en !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_absorb state=%0d cyc=%0d pe=%0b expected 3 2 0", state, cyc_cnt, pipe_en);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run = 1;
    repeat (20) tick();
    n_checks++;
    if (cyc_cnt4 !== 4'd15 || cyc_cnt !== 32'd19) begin
      n_errors++;
      $display("FAIL saturate cyc4=%0d cyc32=%0d expected 15 19", cyc_cnt4, cyc_cnt);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (cyc_cnt4 !== 4'd0 || state4 !== 2'd0 || halted4 !== 1'b0 || stl_cnt4 !== 4'd0 || pipe_en4 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset4 cyc=%0d state=%0d halted=%0b stl=%0d pe=%0b expected all 0",
               cyc_cnt4, state4, halted4, stl_cnt4, pipe_en4);
    end
    rst_n = 1;
    do_reset();
  endtask

  task automatic test_random();
    bit st, pe;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      run      = ($urandom_range(0, 3) != 0);
      step     = $urandom_range(0, 1);
      halt     = ($urandom_range(0, 59) == 0);
      br       = $urandom_range(0, 1);
      memread  = $urandom_range(0, 1);
      rs_id    = 5'($urandom_range(0, 3));
      rt_id    = 5'($urandom_range(0, 3));
      rs_ex    = 5'($urandom_range(0, 3));
      rt_ex    = 5'($urandom_range(0, 3));
      rd_ex    = 5'($urandom_range(0, 3));
      stage_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stage_rw = 2'($urandom_range(0, 3));
      #1;
      st = ref_stall();
      pe = ref_pe();
      n_checks++;
      if (fwd_a !== 2'(ref_fwd(rs_ex)) || fwd_b !== 2'(ref_fwd(rt_ex))) begin
        n_errors++;
        $display("FAIL rnd_fwd i=%0d a=%0d b=%0d expected %0d %0d",
                 i, fwd_a, fwd_b, ref_fwd(rs_ex), ref_fwd(rt_ex));
      end
      n_checks++;
      if (pipe_en !== pe || pc_en !== (pe && !st) || if_id_en !== (pe && !st) ||
          bubble !== (pe && st) || flush !== (pe && br && !st)) begin
        n_errors++;
        $display("FAIL rnd_ctrl i=%0d pe=%0b pc=%0b ifid=%0b bub=%0b fl=%0b expected %0b %0b %0b %0b %0b",
                 i, pipe_en, pc_en, if_id_en, bubble, flush,
                 pe, pe && !st, pe && !st, pe && st, pe && br && !st);
      end
      n_checks++;
      if (state !== 2'(m_state) || halted !== (m_state == 3) || cyc_cnt !== 32'(m_cyc) ||
          stl_cnt !== 32'(m_stl) || cyc_cnt4 !== 4'(m_cyc4) || stl_cnt4 !== 4'(m_stl4)) begin
        n_errors++;
        $display("FAIL rnd_regs i=%0d state=%0d halted=%0b cyc=%0d stl=%0d cyc4=%0d stl4=%0d expected %0d %0b %0d %0d %0d %0d",
                 i, state, halted, cyc_cnt, stl_cnt, cyc_cnt4, stl_cnt4,
                 m_state, m_state == 3, m_cyc, m_stl, m_cyc4, m_stl4);
      end
      tick();
    end
  endtask

  initial begin
    m_state = 0; m_cyc = 0; m_stl = 0; m_cyc4 = 0; m_stl4 = 0;
    #3;
    test_reset();
    test_forwarding();
    test_load_use();
    test_step();
    test_halt();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
